// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master FSM state type.
// Ports: none (package).
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    WRESP     = 3'd2,
    READ_ADDR = 3'd3,
    READ_DATA = 3'd4
  } state_e;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master. Converts one command into AW/W/B or
// AR/R handshakes, reports the response with a one-cycle done pulse, and
// aborts any transaction that exceeds TIMEOUT cycles.
// Ports:
//   ACLK, ARESET            clock, synchronous active-high reset
//   cmd_*                   command in (valid/ready), cmd_ready is combinational
//   done, rsp_*             completion pulse and held response
//   M_AW*, M_W*, M_B*       AXI4-Lite write channels
//   M_AR*, M_R*             AXI4-Lite read channels
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDRESS    = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDRESS-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic [ADDRESS-1:0]    M_AWADDR,
  output logic                  M_AWVALID,
  input  logic                  M_AWREADY,
  output logic [DATA_WIDTH-1:0] M_WDATA,
  output logic [3:0]            M_WSTRB,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,
  input  logic [1:0]            M_BRESP,
  input  logic                  M_BVALID,
  output logic                  M_BREADY,
  output logic [ADDRESS-1:0]    M_ARADDR,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RVALID,
  output logic                  M_RREADY
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q,  wvalid_d;
  logic                  bready_q,  bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q,  rready_d;
  logic                  done_q,    done_d;
  logic                  timeout_q, timeout_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]            resp_q,    resp_d;
  logic [ADDRESS-1:0]    awaddr_q,  awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [3:0]            wstrb_q,   wstrb_d;
  logic [ADDRESS-1:0]    araddr_q,  araddr_d;

  logic aw_hs;
  logic w_hs;
  logic aw_clear;
  logic w_clear;

  assign aw_hs = awvalid_q & M_AWREADY;
  assign w_hs  = wvalid_q & M_WREADY;
  // A write channel is finished once its VALID has dropped or is handshaking now.
  assign aw_clear = aw_hs | ~awvalid_q;
  assign w_clear  = w_hs | ~wvalid_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    araddr_d  = araddr_q;

    // Watchdog saturates at its last value so a late handshake cannot wrap it.
    if (state_q != IDLE && cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cnt_d = '0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = READ_ADDR;
          end
        end
      end
      WRITE: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (aw_clear && w_clear) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (M_BVALID) begin
          resp_d    = M_BRESP;
          timeout_d = 1'b0;
          done_d    = 1'b1;
          bready_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      READ_ADDR: begin
        if (M_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = READ_DATA;
        end
      end
      READ_DATA: begin
        if (M_RVALID) begin
          rdata_d   = M_RDATA;
          resp_d    = M_RRESP;
          timeout_d = 1'b0;
          rready_d  = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort only when no state-advancing handshake happens this cycle.
    if (state_q != IDLE && state_d == state_q && cnt_q == CNT_LAST) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      done_d    = 1'b1;
      timeout_d = 1'b1;
      resp_d    = RESP_SLVERR;
      state_d   = IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      araddr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      araddr_q  <= araddr_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign done        = done_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = timeout_q;
  assign M_AWADDR    = awaddr_q;
  assign M_AWVALID   = awvalid_q;
  assign M_WDATA     = wdata_q;
  assign M_WSTRB     = wstrb_q;
  assign M_WVALID    = wvalid_q;
  assign M_BREADY    = bready_q;
  assign M_ARADDR    = araddr_q;
  assign M_ARVALID   = arvalid_q;
  assign M_RREADY    = rready_q;

endmodule
